// File: rtl/counter_up_ctrl.sv
// Up counter from 0 to a programmable terminal value with start/enable/clear control.
// Either wraps to 0 (counting wrap events) or stops in DONE; every output is registered.
module counter_up_ctrl #(
    parameter int dw    = 8,
    parameter int LIMIT = 7,
    parameter bit WRAP  = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ena,
    input  logic          clear,
    output logic [dw-1:0] result,
    output logic          tc,
    output logic          busy,
    output logic          done,
    output logic [dw-1:0] wraps
);

    if (LIMIT < 0 || longint'(LIMIT) >= (longint'(1) << dw)) begin : g_bad_limit
        $error("counter_up_ctrl: LIMIT %0d does not fit in %0d bits", LIMIT, dw);
    end

    localparam logic [dw-1:0] LIM        = dw'(LIMIT);
    localparam bit            LIMIT_ZERO = (LIMIT == 0);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [dw-1:0] result_n, wraps_n, result_inc;
    logic          tc_n;

    assign result_inc = result + 1'b1;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        result_n = result;
        wraps_n  = wraps;
        tc_n     = 1'b0;
        if (clear) begin
            state_n  = IDLE;
            result_n = '0;
            wraps_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_n  = RUN;
                        result_n = '0;
                    end
                end
                RUN: begin
                    if (ena) begin
                        // result never exceeds LIM, so "not at LIM" means "below LIM"
                        if (result != LIM) begin
                            result_n = result_inc;
                            tc_n     = (result_inc == LIM);
                        end else begin
                            tc_n = LIMIT_ZERO;
                            if (WRAP) begin
                                result_n = '0;
                                wraps_n  = wraps + 1'b1;
                            end else begin
                                state_n = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_n  = RUN;
                        result_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            result <= '0;
            wraps  <= '0;
            tc     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            result <= result_n;
            wraps  <= wraps_n;
            tc     <= tc_n;
            busy   <= (state_n == RUN);
            done   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_counter_up_ctrl.sv
// Directed bench: four counter configurations share one stimulus stream and are
// checked against hand-computed values, one phase at a time.
module tb_counter_up_ctrl;

    logic clk = 1'b0;
    logic reset, start, ena, clear;

    int checks = 0;
    int errors = 0;

    // LIMIT=7, WRAP=1
    logic [7:0] w_result, w_wraps;
    logic       w_tc, w_busy, w_done;
    // LIMIT=7, WRAP=0
    logic [7:0] s_result, s_wraps;
    logic       s_tc, s_busy, s_done;
    // LIMIT=0, WRAP=1
    logic [7:0] z_result, z_wraps;
    logic       z_tc, z_busy, z_done;
    // dw=2, LIMIT=3, WRAP=1
    logic [1:0] n_result, n_wraps;
    logic       n_tc, n_busy, n_done;

    counter_up_ctrl #(.dw(8), .LIMIT(7), .WRAP(1'b1)) u_w (
        .clk(clk), .reset(reset), .start(start), .ena(ena), .clear(clear),
        .result(w_result), .tc(w_tc), .busy(w_busy), .done(w_done), .wraps(w_wraps));

    counter_up_ctrl #(.dw(8), .LIMIT(7), .WRAP(1'b0)) u_s (
        .clk(clk), .reset(reset), .start(start), .ena(ena), .clear(clear),
        .result(s_result), .tc(s_tc), .busy(s_busy), .done(s_done), .wraps(s_wraps));

    counter_up_ctrl #(.dw(8), .LIMIT(0), .WRAP(1'b1)) u_z (
        .clk(clk), .reset(reset), .start(start), .ena(ena), .clear(clear),
        .result(z_result), .tc(z_tc), .busy(z_busy), .done(z_done), .wraps(z_wraps));

    counter_up_ctrl #(.dw(2), .LIMIT(3), .WRAP(1'b1)) u_n (
        .clk(clk), .reset(reset), .start(start), .ena(ena), .clear(clear),
        .result(n_result), .tc(n_tc), .busy(n_busy), .done(n_done), .wraps(n_wraps));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_w(input string tag, input int r, input int wr, input bit t, input bit b, input bit d);
        check({tag, ".result"}, 32'(w_result), 32'(r));
        check({tag, ".wraps"},  32'(w_wraps),  32'(wr));
        check({tag, ".tc"},     32'(w_tc),     32'(t));
        check({tag, ".busy"},   32'(w_busy),   32'(b));
        check({tag, ".done"},   32'(w_done),   32'(d));
    endtask

    task automatic check_s(input string tag, input int r, input bit t, input bit b, input bit d);
        check({tag, ".s_result"}, 32'(s_result), 32'(r));
        check({tag, ".s_tc"},     32'(s_tc),     32'(t));
        check({tag, ".s_busy"},   32'(s_busy),   32'(b));
        check({tag, ".s_done"},   32'(s_done),   32'(d));
    endtask

    initial begin
        int exp_pause [6];
        bit exp_tc    [6];
        bit ena_pause [6];
        ena_pause = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_pause = '{6, 6, 6, 7, 7, 0};
        exp_tc    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset held for two cycles with start/ena high
        reset = 1'b0; start = 1'b1; ena = 1'b1; clear = 1'b0;
        tick(); tick();
        check_w("reset", 0, 0, 1'b0, 1'b0, 1'b0);
        check_s("reset", 0, 1'b0, 1'b0, 1'b0);

        // Release with start and ena together: RUN, no increment yet
        reset = 1'b1;
        tick();
        check_w("start", 0, 0, 1'b0, 1'b1, 1'b0);
        check_s("start", 0, 1'b0, 1'b1, 1'b0);
        check("start.z_result", 32'(z_result), 32'd0);
        check("start.n_result", 32'(n_result), 32'd0);

        // 20 enabled cycles: wrap, stop, LIMIT=0 and narrow-width runs in parallel
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("wrap%0d.result", i), 32'(w_result), 32'(i % 8));
            check($sformatf("wrap%0d.tc", i),     32'(w_tc),     32'(i % 8 == 7));
            if (i <= 10) begin
                if (i <= 7) check_s($sformatf("stop%0d", i), i, (i == 7), 1'b1, 1'b0);
                else        check_s($sformatf("stop%0d", i), 7, 1'b0, 1'b0, 1'b1);
            end
            if (i <= 5) begin
                check($sformatf("zero%0d.tc", i),     32'(z_tc),     32'd1);
                check($sformatf("zero%0d.wraps", i),  32'(z_wraps),  32'(i));
                check($sformatf("zero%0d.result", i), 32'(z_result), 32'd0);
            end
            if (i <= 18) begin
                check($sformatf("narrow%0d.result", i), 32'(n_result), 32'(i % 4));
                check($sformatf("narrow%0d.wraps", i),  32'(n_wraps),  32'((i / 4) % 4));
            end
        end
        check_w("wrap_end", 4, 2, 1'b0, 1'b1, 1'b0);

        // Restart the stopped counter; start is ignored by the running one
        ena = 1'b0; start = 1'b1;
        tick();
        check_s("restart", 0, 1'b0, 1'b1, 1'b0);
        check_w("start_in_run", 4, 2, 1'b0, 1'b1, 1'b0);

        // Pause pattern from result=5
        start = 1'b0; ena = 1'b1;
        tick();
        check("pause_pre.result", 32'(w_result), 32'd5);
        for (int i = 0; i < 6; i++) begin
            ena = ena_pause[i];
            tick();
            check($sformatf("pause%0d.result", i), 32'(w_result), 32'(exp_pause[i]));
            check($sformatf("pause%0d.tc", i),     32'(w_tc),     32'(exp_tc[i]));
        end
        check("pause_end.wraps", 32'(w_wraps), 32'd3);

        // Advance to 4, then clear together with start
        ena = 1'b1;
        repeat (4) tick();
        check("pre_clear.result", 32'(w_result), 32'd4);
        clear = 1'b1; start = 1'b1;
        tick();
        check_w("clear_start", 0, 0, 1'b0, 1'b0, 1'b0);

        // ena alone does nothing in IDLE
        clear = 1'b0; start = 1'b0; ena = 1'b1;
        tick();
        check_w("idle_ena", 0, 0, 1'b0, 1'b0, 1'b0);

        // Run to 3, then reset together with clear/start/ena
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("pre_reset.result", 32'(w_result), 32'd3);
        reset = 1'b0; clear = 1'b1; start = 1'b1; ena = 1'b1;
        tick();
        check_w("reset_clear", 0, 0, 1'b0, 1'b0, 1'b0);
        check_s("reset_clear", 0, 1'b0, 1'b0, 1'b0);
        check("reset_clear.z_wraps", 32'(z_wraps), 32'd0);
        check("reset_clear.n_wraps", 32'(n_wraps), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
